// File: rtl/hdc_bundle_ctrl.sv
// Hyperdimensional bundling controller: per-lane accumulators gated by a valid/ready stream,
// majority threshold at end of bundle, result presented on a valid/ready output.
module hdc_bundle_ctrl #(
  parameter int unsigned D    = 64,
  parameter int unsigned NMAX = 255,
  parameter bit          TIE  = 1'b0,
  localparam int unsigned CW  = $clog2(NMAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [D-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [D-1:0]  out_data,
  output logic [CW-1:0] out_count,
  output logic          busy,
  output logic          sat
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StThresh,
    StOut
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] lane_q [D];
  logic [CW-1:0] n_q;
  logic [CW-1:0] n_inc;
  logic [D-1:0]  out_data_q;
  logic [CW-1:0] out_count_q;
  logic          sat_q;

  logic          hs;
  logic          clr_en;
  logic          acc_en;
  logic          thr_en;
  logic          sat_set;
  logic          sat_clr;
  logic [D-1:0]  thr_data;

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign sat       = sat_q;

  assign hs    = in_valid & in_ready;
  assign n_inc = n_q + CW'(1);

  // Next-state decode; abort outranks every other event outside IDLE.
  always_comb begin
    state_d = state_q;
    clr_en  = 1'b0;
    acc_en  = 1'b0;
    thr_en  = 1'b0;
    sat_set = 1'b0;
    sat_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StClear;
          sat_clr = 1'b1;
        end
      end
      StClear: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          clr_en  = 1'b1;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (abort) begin
          state_d = StIdle;
        end else if (hs) begin
          acc_en = 1'b1;
          if (in_last) begin
            state_d = StThresh;
          end else if (n_inc == CW'(NMAX)) begin
            state_d = StThresh;
            sat_set = 1'b1;
          end
        end
      end
      StThresh: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          thr_en  = 1'b1;
          state_d = StOut;
        end
      end
      StOut: begin
        if (abort || out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Majority vote: compare 2*lane against n with one extra bit so the doubling cannot overflow.
  always_comb begin
    thr_data = '0;
    for (int i = 0; i < D; i++) begin
      if ({lane_q[i], 1'b0} > {1'b0, n_q}) begin
        thr_data[i] = 1'b1;
      end else if ({lane_q[i], 1'b0} < {1'b0, n_q}) begin
        thr_data[i] = 1'b0;
      end else begin
        thr_data[i] = TIE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        lane_q[i] <= '0;
      end
      n_q <= '0;
    end else if (clr_en) begin
      for (int i = 0; i < D; i++) begin
        lane_q[i] <= '0;
      end
      n_q <= '0;
    end else if (acc_en) begin
      for (int i = 0; i < D; i++) begin
        lane_q[i] <= lane_q[i] + CW'(in_data[i]);
      end
      n_q <= n_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_count_q <= '0;
    end else if (thr_en) begin
      out_data_q  <= thr_data;
      out_count_q <= n_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (sat_clr) begin
      sat_q <= 1'b0;
    end else if (sat_set) begin
      sat_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hdc_bundle_ctrl.sv
// Scoreboard bench: two instances (NMAX=255/TIE=0 and NMAX=3/TIE=1) share stimulus,
// expected results are queued at issue time and checked by a monitor at each output handshake.
module tb_hdc_bundle_ctrl;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] count;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, in_valid, in_last, out_ready;
  logic [7:0] in_data;
  logic       en_a, en_b;

  logic       in_ready_a, out_valid_a, busy_a, sat_a;
  logic [7:0] out_data_a, out_count_a;
  logic       in_ready_b, out_valid_b, busy_b, sat_b;
  logic [7:0] out_data_b;
  logic [1:0] out_count_b;

  int checks   = 0;
  int failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  hdc_bundle_ctrl #(.D(8), .NMAX(255), .TIE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(start & en_a), .abort(abort),
    .in_valid(in_valid & en_a), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_count(out_count_a), .busy(busy_a), .sat(sat_a)
  );

  hdc_bundle_ctrl #(.D(8), .NMAX(3), .TIE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start & en_b), .abort(abort),
    .in_valid(in_valid & en_b), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_count(out_count_b), .busy(busy_b), .sat(sat_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compare against the scoreboard whenever an output handshake occurs.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid_a && out_ready) begin
        if (q_a.size() == 0) begin
          fail_now("a_unexpected_output");
        end else begin
          e = q_a.pop_front();
          chk("a_out_data", 32'(out_data_a), 32'(e.data));
          chk("a_out_count", 32'(out_count_a), 32'(e.count));
          chk("a_sat", 32'(sat_a), 32'(e.sat));
        end
      end
      if (out_valid_b && out_ready) begin
        if (q_b.size() == 0) begin
          fail_now("b_unexpected_output");
        end else begin
          e = q_b.pop_front();
          chk("b_out_data", 32'(out_data_b), 32'(e.data));
          chk("b_out_count", 32'(out_count_b), 32'(e.count));
          chk("b_sat", 32'(sat_b), 32'(e.sat));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy();
    return (!en_a || in_ready_a) && (!en_b || in_ready_b);
  endfunction

  function automatic logic ovld();
    return (!en_a || out_valid_a) && (!en_b || out_valid_b);
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int k = 0; k < 20 && !done; k++) begin
      if (rdy()) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) fail_now("send_timeout");
  endtask

  task automatic wait_out();
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (ovld()) seen = 1'b1;
      else tick();
    end
    if (!seen) fail_now("out_valid_timeout");
  endtask

  task automatic drain();
    wait_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic push(input logic [7:0] da, input logic [7:0] db, input logic [7:0] cnt,
                      input logic sat_exp);
    if (en_a) q_a.push_back('{data: da, count: cnt, sat: 1'b0});
    if (en_b) q_b.push_back('{data: db, count: cnt, sat: sat_exp});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_data = 8'h00; en_a = 1'b1; en_b = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_in_ready_a", 32'(in_ready_a), 0);
    chk("rst_out_valid_a", 32'(out_valid_a), 0);
    chk("rst_sat_a", 32'(sat_a), 0);
    chk("rst_out_data_a", 32'(out_data_a), 0);
    chk("rst_out_count_a", 32'(out_count_a), 0);
    chk("rst_busy_b", 32'(busy_b), 0);

    // Three-vector majority and two-cycle latency
    push(8'hE8, 8'hE8, 8'd3, 1'b0);
    do_start();
    send(8'hF0, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hAA, 1'b1);
    chk("lat_thresh_valid_a", 32'(out_valid_a), 0);
    chk("lat_thresh_in_ready_a", 32'(in_ready_a), 0);
    tick();
    chk("lat_out_valid_a", 32'(out_valid_a), 1);
    chk("lat_out_valid_b", 32'(out_valid_b), 1);
    drain();
    chk("idle_after_out_a", 32'(busy_a), 0);

    // Tie handling plus backpressure with ignored start pulses
    push(8'h0F, 8'hFF, 8'd2, 1'b0);
    do_start();
    send(8'hFF, 1'b0);
    send(8'h0F, 1'b1);
    wait_out();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_a", 32'(out_valid_a), 1);
      chk("bp_data_a", 32'(out_data_a), 32'h0F);
      chk("bp_data_b", 32'(out_data_b), 32'hFF);
      chk("bp_count_a", 32'(out_count_a), 2);
      start = (k % 2 == 0);
      tick();
    end
    start = 1'b0;
    drain();
    chk("bp_idle_a", 32'(busy_a), 0);
    chk("bp_out_valid_low_b", 32'(out_valid_b), 0);

    // NMAX saturation on the NMAX=3 instance only
    en_a = 1'b0;
    push(8'h00, 8'h01, 8'd3, 1'b1);
    do_start();
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h01;
    chk("sat_in_ready_4th_b", 32'(in_ready_b), 0);
    chk("sat_set_b", 32'(sat_b), 1);
    tick();
    in_valid = 1'b0;
    chk("sat_out_valid_b", 32'(out_valid_b), 1);
    drain();
    chk("sat_sticky_b", 32'(sat_b), 1);
    en_a = 1'b1;

    // Abort with a simultaneous handshake, then a fresh single-vector bundle
    do_start();
    chk("sat_cleared_b", 32'(sat_b), 0);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy_a", 32'(busy_a), 0);
    chk("abort_busy_b", 32'(busy_b), 0);
    chk("abort_out_valid_a", 32'(out_valid_a), 0);
    tick();
    chk("abort_no_output_a", 32'(out_valid_a), 0);
    push(8'h3C, 8'h3C, 8'd1, 1'b0);
    do_start();
    send(8'h3C, 1'b1);
    drain();

    // start together with abort in IDLE stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle_a", 32'(busy_a), 0);

    // Asynchronous reset mid-bundle
    do_start();
    send(8'h55, 1'b0);
    chk("pre_rst_busy_a", 32'(busy_a), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy_a", 32'(busy_a), 0);
    chk("arst_in_ready_a", 32'(in_ready_a), 0);
    chk("arst_out_valid_a", 32'(out_valid_a), 0);
    chk("arst_sat_a", 32'(sat_a), 0);
    chk("arst_busy_b", 32'(busy_b), 0);
    rst = 1'b0;
    tick();
    push(8'h81, 8'h81, 8'd1, 1'b0);
    do_start();
    send(8'h81, 1'b1);
    drain();
    tick();

    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
